// File: rtl/step_ctrl.sv
// Frequency step controller: manual up/down keys or an automatic triangle sweep of the tuning word.
// Latency: one clk from a key pulse or sweep tick to the new step_val; step_upd/at_limit update with it.
// Backpressure: none. Keys and sweep_en are sampled every cycle; a key that cannot act is dropped.
module step_ctrl #(
  parameter logic [31:0] STEP_MIN  = 32'd85899,
  parameter logic [31:0] STEP_MAX  = 32'd85899346,
  parameter logic [31:0] STEP_INC  = 32'd85899,
  parameter logic [23:0] SWEEP_DIV = 24'd50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_up,
  input  logic        key_down,
  input  logic        sweep_en,
  output logic [31:0] step_val,
  output logic        step_upd,
  output logic        sweeping,
  output logic        at_limit
);

  typedef enum logic [1:0] {
    MANUAL     = 2'd0,
    SWEEP_UP   = 2'd1,
    SWEEP_DOWN = 2'd2
  } state_t;

  state_t      state;
  logic [23:0] dwell_cnt;

  // Saturated neighbours of the current word. The sums are 33 bits wide so
  // neither the add nor the lower-bound compare can wrap at 2^32.
  logic [32:0] sum33;
  logic [32:0] lo33;
  logic [31:0] up_sat;
  logic [31:0] dn_sat;
  logic        dwell_wrap;

  // Candidate next values shared by manual keys and sweep ticks.
  always_comb begin
    sum33      = {1'b0, step_val} + {1'b0, STEP_INC};
    lo33       = {1'b0, STEP_MIN} + {1'b0, STEP_INC};
    up_sat     = (sum33 >= {1'b0, STEP_MAX}) ? STEP_MAX : sum33[31:0];
    // At step_val == MIN+INC both branches give STEP_MIN, so "<=" serves both
    // the manual max() rule and the sweep turn-around rule.
    dn_sat     = ({1'b0, step_val} <= lo33) ? STEP_MIN : (step_val - STEP_INC);
    dwell_wrap = (dwell_cnt == (SWEEP_DIV - 24'd1));
  end

  function automatic logic is_limit(input logic [31:0] v);
    return (v == STEP_MIN) || (v == STEP_MAX);
  endfunction

  // Mode FSM, dwell counter and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= MANUAL;
      dwell_cnt <= 24'd0;
      step_val  <= STEP_MIN;
      step_upd  <= 1'b0;
      sweeping  <= 1'b0;
      at_limit  <= 1'b1;
    end else begin
      step_upd <= 1'b0;
      case (state)
        MANUAL: begin
          if (sweep_en) begin
            // Keys are dropped on the transition edge.
            state     <= SWEEP_UP;
            dwell_cnt <= 24'd0;
            sweeping  <= 1'b1;
          end else if (key_up && !key_down) begin
            step_val <= up_sat;
            at_limit <= is_limit(up_sat);
            step_upd <= (up_sat != step_val);
          end else if (key_down && !key_up) begin
            step_val <= dn_sat;
            at_limit <= is_limit(dn_sat);
            step_upd <= (dn_sat != step_val);
          end
        end

        SWEEP_UP, SWEEP_DOWN: begin
          if (!sweep_en) begin
            // Leave sweep holding the current word.
            state     <= MANUAL;
            dwell_cnt <= 24'd0;
            sweeping  <= 1'b0;
          end else if (!dwell_wrap) begin
            dwell_cnt <= dwell_cnt + 24'd1;
          end else begin
            dwell_cnt <= 24'd0;
            if (state == SWEEP_UP) begin
              step_val <= up_sat;
              at_limit <= is_limit(up_sat);
              step_upd <= (up_sat != step_val);
              if (sum33 >= {1'b0, STEP_MAX}) state <= SWEEP_DOWN;
            end else begin
              step_val <= dn_sat;
              at_limit <= is_limit(dn_sat);
              step_upd <= (dn_sat != step_val);
              if ({1'b0, step_val} <= lo33) state <= SWEEP_UP;
            end
          end
        end

        default: begin
          state     <= MANUAL;
          dwell_cnt <= 24'd0;
          sweeping  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_step_ctrl.sv
// Directed bench for step_ctrl: manual keys, saturation, sweep, async reset, full-range wrap guard.
// Inputs change 1ns after a rising edge; outputs are sampled there too.
// Two instances: small-range parameters and a full 32-bit range instance.
module tb_step_ctrl;

  logic        clk;
  logic        rst, key_up, key_down, sweep_en;
  logic [31:0] step_val;
  logic        step_upd, sweeping, at_limit;

  logic        rst_b, key_up_b, key_down_b, sweep_en_b;
  logic [31:0] step_val_b;
  logic        step_upd_b, sweeping_b, at_limit_b;

  int checks = 0;
  int errors = 0;

  step_ctrl #(
    .STEP_MIN(32'd100), .STEP_MAX(32'd130), .STEP_INC(32'd10), .SWEEP_DIV(24'd4)
  ) dut_a (
    .clk(clk), .rst(rst), .key_up(key_up), .key_down(key_down), .sweep_en(sweep_en),
    .step_val(step_val), .step_upd(step_upd), .sweeping(sweeping), .at_limit(at_limit)
  );

  step_ctrl #(
    .STEP_MIN(32'd0), .STEP_MAX(32'hFFFF_FFFF), .STEP_INC(32'h8000_0000), .SWEEP_DIV(24'd4)
  ) dut_b (
    .clk(clk), .rst(rst_b), .key_up(key_up_b), .key_down(key_down_b), .sweep_en(sweep_en_b),
    .step_val(step_val_b), .step_upd(step_upd_b), .sweeping(sweeping_b), .at_limit(at_limit_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Check value, update pulse and limit flag of instance A together.
  task automatic chk_a(input string tag, input logic [31:0] v, input logic upd, input logic lim);
    check({tag, ".val"}, step_val, v);
    check({tag, ".upd"}, {31'd0, step_upd}, {31'd0, upd});
    check({tag, ".lim"}, {31'd0, at_limit}, {31'd0, lim});
  endtask

  task automatic press_a(input logic up, input logic dn);
    key_up = up; key_down = dn;
    cyc();
    key_up = 1'b0; key_down = 1'b0;
  endtask

  task automatic press_b(input logic up, input logic dn);
    key_up_b = up; key_down_b = dn;
    cyc();
    key_up_b = 1'b0; key_down_b = 1'b0;
  endtask

  logic [31:0] sweep_exp [7] = '{32'd110, 32'd120, 32'd130, 32'd120, 32'd110, 32'd100, 32'd110};
  logic [31:0] b_exp     [5] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0, 32'h0};
  logic        b_up      [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    rst = 1'b1; key_up = 1'b0; key_down = 1'b0; sweep_en = 1'b0;
    rst_b = 1'b1; key_up_b = 1'b0; key_down_b = 1'b0; sweep_en_b = 1'b0;
    #1;
    chk_a("rst", 32'd100, 1'b0, 1'b1);
    check("rst.sweeping", {31'd0, sweeping}, 32'd0);
    check("rst_b.val", step_val_b, 32'd0);
    cyc();
    rst = 1'b0; rst_b = 1'b0;
    cyc();
    chk_a("idle", 32'd100, 1'b0, 1'b1);

    // Three key_up presses, each visible one edge later.
    press_a(1'b1, 1'b0); chk_a("up1", 32'd110, 1'b1, 1'b0);
    cyc();               chk_a("up1.hold", 32'd110, 1'b0, 1'b0);
    press_a(1'b1, 1'b0); chk_a("up2", 32'd120, 1'b1, 1'b0);
    press_a(1'b1, 1'b0); chk_a("up3", 32'd130, 1'b1, 1'b1);

    // Saturation at MAX, both keys together, then key_down.
    press_a(1'b1, 1'b0); chk_a("up_sat", 32'd130, 1'b0, 1'b1);
    press_a(1'b1, 1'b1); chk_a("both", 32'd130, 1'b0, 1'b1);
    press_a(1'b0, 1'b1); chk_a("dn1", 32'd120, 1'b1, 1'b0);
    press_a(1'b0, 1'b1); chk_a("dn2", 32'd110, 1'b1, 1'b0);
    press_a(1'b0, 1'b1); chk_a("dn3", 32'd100, 1'b1, 1'b1);
    press_a(1'b0, 1'b1); chk_a("dn_sat", 32'd100, 1'b0, 1'b1);

    // Triangle sweep from 100, one tick every 4 edges after entry.
    sweep_en = 1'b1;
    cyc();
    check("sw.enter", {31'd0, sweeping}, 32'd1);
    check("sw.enter.val", step_val, 32'd100);
    for (int i = 0; i < 7; i++) begin
      repeat (3) cyc();
      check($sformatf("sw%0d.dwell", i), step_val, (i == 0) ? 32'd100 : sweep_exp[i-1]);
      cyc();
      check($sformatf("sw%0d.val", i), step_val, sweep_exp[i]);
      check($sformatf("sw%0d.upd", i), {31'd0, step_upd}, 32'd1);
    end
    repeat (4) cyc();
    check("sw.at120", step_val, 32'd120);

    // Keys ignored mid-sweep, then exit to manual holding 120.
    press_a(1'b1, 1'b0); chk_a("sw.key_up", 32'd120, 1'b0, 1'b0);
    press_a(1'b0, 1'b1); chk_a("sw.key_dn", 32'd120, 1'b0, 1'b0);
    sweep_en = 1'b0;
    cyc();
    check("exit.sweeping", {31'd0, sweeping}, 32'd0);
    check("exit.val", step_val, 32'd120);
    repeat (3) cyc();
    check("exit.hold", step_val, 32'd120);
    press_a(1'b0, 1'b1); chk_a("exit.dn", 32'd110, 1'b1, 1'b0);
    press_a(1'b1, 1'b0); chk_a("exit.up", 32'd120, 1'b1, 1'b0);

    // Async reset between edges mid-sweep.
    sweep_en = 1'b1;
    repeat (2) cyc();
    check("rs.sweeping", {31'd0, sweeping}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk_a("rs.async", 32'd100, 1'b0, 1'b1);
    check("rs.async.sweeping", {31'd0, sweeping}, 32'd0);
    cyc();
    rst = 1'b0;
    cyc();
    check("rs.reenter", {31'd0, sweeping}, 32'd1);
    check("rs.reenter.val", step_val, 32'd100);
    repeat (4) cyc();
    check("rs.tick", step_val, 32'd110);

    // Sweep entry while already at MAX: first tick turns around without a change.
    sweep_en = 1'b0;
    cyc();
    press_a(1'b1, 1'b0);
    press_a(1'b1, 1'b0);
    check("max.pre", step_val, 32'd130);
    sweep_en = 1'b1;
    repeat (5) cyc();
    chk_a("max.tick1", 32'd130, 1'b0, 1'b1);
    repeat (4) cyc();
    chk_a("max.tick2", 32'd120, 1'b1, 1'b0);
    sweep_en = 1'b0;

    // Full 32-bit range: no wrap on add or subtract.
    for (int i = 0; i < 5; i++) begin
      press_b(b_up[i], !b_up[i]);
      check($sformatf("wide%0d", i), step_val_b, b_exp[i]);
    end
    check("wide.lim", {31'd0, at_limit_b}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/step_ctrl.md
STEP_CTRL -- requirements
Module: step_ctrl

Interface
REQ-001 Parameter STEP_MIN, default 32'd85899, SHALL be the lowest step_val allowed (1 kHz at 50 MHz clk).
REQ-002 Parameter STEP_MAX, default 32'd85899346, SHALL be the highest step_val allowed (1 MHz at 50 MHz clk).
REQ-003 Parameter STEP_INC, default 32'd85899, SHALL be the step_val change per key press or sweep tick.
REQ-004 Parameter SWEEP_DIV, default 24'd50000, SHALL be the dwell, in clk cycles, between sweep ticks.
REQ-005 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-007 key_up  input  1  SHALL be a 1-cycle pulse requesting step_val + STEP_INC (already synchronised and debounced upstream).
REQ-008 key_down  input  1  SHALL be a 1-cycle pulse requesting step_val - STEP_INC.
REQ-009 sweep_en  input  1  SHALL be a level; high selects automatic sweep, low selects manual mode.
REQ-010 step_val  output  32  SHALL be the registered frequency tuning word driven to the phase accumulator.
REQ-011 step_upd  output  1  SHALL pulse high for 1 cycle in the cycle step_val takes a new value.
REQ-012 sweeping  output  1  SHALL be high while the FSM is in SWEEP_UP or SWEEP_DOWN.
REQ-013 at_limit  output  1  SHALL be high whenever step_val equals STEP_MIN or STEP_MAX (registered together with step_val).

Function
REQ-014 Legal parameters SHALL satisfy STEP_MIN < STEP_MAX, STEP_INC >= 1, SWEEP_DIV >= 1; other values are unsupported.
REQ-015 FSM states SHALL be MANUAL, SWEEP_UP, SWEEP_DOWN.
REQ-016 MANUAL -> SWEEP_UP SHALL occur on the first clk edge with sweep_en high; dwell counter cleared to 0 on that edge.
REQ-017 SWEEP_UP or SWEEP_DOWN -> MANUAL SHALL occur on the first clk edge with sweep_en low; step_val holds its current value; counter cleared.
REQ-018 In MANUAL, key_up alone SHALL set step_val to min(step_val + STEP_INC, STEP_MAX) on the next edge (latency 1 cycle).
REQ-019 In MANUAL, key_down alone SHALL set step_val to max(step_val - STEP_INC, STEP_MIN) on the next edge.
REQ-020 Saturation comparisons SHALL use 33-bit arithmetic so that no add/subtract wraps modulo 2^32.
REQ-021 key_up and key_down high together SHALL leave step_val unchanged, with step_upd low.
REQ-022 A key press at the matching limit (key_up at STEP_MAX, key_down at STEP_MIN) SHALL leave step_val unchanged, with step_upd low.
REQ-023 key_up and key_down SHALL be ignored in SWEEP_UP/SWEEP_DOWN and in the cycle of any mode transition.
REQ-024 In sweep states the dwell counter SHALL count 0..SWEEP_DIV-1 and wrap; a tick SHALL occur on the edge where it wraps, i.e. first tick SWEEP_DIV cycles after sweep entry.
REQ-025 SWEEP_UP tick: if step_val + STEP_INC >= STEP_MAX, step_val := STEP_MAX and state := SWEEP_DOWN; else step_val += STEP_INC.
REQ-026 SWEEP_DOWN tick: if step_val <= STEP_MIN + STEP_INC, step_val := STEP_MIN and state := SWEEP_UP; else step_val -= STEP_INC.
REQ-027 Entry to SWEEP_UP while step_val == STEP_MAX SHALL, at the first tick, leave step_val at STEP_MAX and move to SWEEP_DOWN, with step_upd low.
REQ-028 step_upd SHALL be high exactly on cycles where the registered step_val differs from its previous value.

Reset
REQ-029 While rst is high: step_val = STEP_MIN, at_limit = 1, step_upd = 0, sweeping = 0, state = MANUAL, dwell counter = 0, independent of clk.
REQ-030 Reset asserted mid-sweep SHALL abort the sweep immediately; after release the block resumes in MANUAL, and sweep_en still high re-enters SWEEP_UP on the first edge.

Verification (bench parameters STEP_MIN=100, STEP_MAX=130, STEP_INC=10, SWEEP_DIV=4)
REQ-031 Reset, release, 3x key_up -> step_val 110,120,130, each 1 cycle after its pulse; step_upd pulses 3 times; at_limit=1 only at 130.
REQ-032 At 130, key_up -> step_val stays 130, step_upd=0; then key_up+key_down together -> no change; key_down -> 120.
REQ-033 From 100, sweep_en=1 held -> sweeping=1; step_val 110,120,130,120,110,100,110 at 4-cycle intervals; first change 4 cycles after entry.
REQ-034 Mid-sweep at 120, key_up/key_down pulses -> ignored; sweep_en=0 -> sweeping=0, step_val holds 120; next key_down -> 110.
REQ-035 Mid-sweep at 120, assert rst asynchronously between edges -> step_val=100, sweeping=0 immediately, without waiting for a clk edge.
REQ-036 Reset with STEP_MIN=0, STEP_MAX=32'hFFFFFFFF, STEP_INC=32'h80000000, then key_up x2, key_down x3 -> step_val 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 0, 0 (no wrap).
